// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM:
//   - state encodings (FETCH=0 .. JUMP=9, optional ADDI_EXEC=10 / ADDI_WB=11)
//   - opcode constants for the supported instructions
//   - ALUOp, alu_src_b and pc_source select codes
//   - ctrl_word_t: the full set of datapath enables/selects driven per state
//   - op_is_legal(): opcode support check used for the illegal_op pulse
// Optional build macro: MIPS_CTRL_ADDI_EN (adds addi, opcode 0x08).
package mips_ctrl_pkg;

    localparam int ST_W = 4;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_RD    = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WR    = 4'd5;
    localparam logic [3:0] ST_R_EXEC    = 4'd6;
    localparam logic [3:0] ST_R_WB      = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
    localparam logic [3:0] ST_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
        legal = legal || (op == OP_ADDI);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec
// Purely combinational Moore decode: current state -> control word.
// Ports:
//   state (in, STATE_W) : current FSM state
//   ctrl  (out)         : ctrl_word_t with every datapath enable/select
// Unused encodings decode to an all-zero word.
// Optional build macro: MIPS_CTRL_ADDI_EN (decodes ADDI_EXEC / ADDI_WB).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    output ctrl_word_t         ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Branch target precomputed speculatively into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; the control word comes from mips_ctrl_outdec.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   opcode              : IR[31:26], only examined in DECODE
//   pc_write .. pc_source : datapath enables and mux selects (Moore outputs)
//   instr_done          : pulse in the final state of each instruction
//   illegal_op          : pulse in DECODE for an unsupported opcode
//   state               : current state for debug
// While rst_n is low every output, state included, is held at 0.
// Optional build macro: MIPS_CTRL_ADDI_EN (adds addi, opcode 0x08).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    // lw/sw choice captured in DECODE so MEM_ADDR never looks at opcode again.
    logic               r_is_sw;
    logic               w_is_sw_next;
    logic               w_illegal;
    ctrl_word_t         w_ctrl;
    ctrl_word_t         w_ctrl_gated;

    always_comb begin
        w_state_next = ST_FETCH;
        w_is_sw_next = r_is_sw;
        case (r_state)
            ST_FETCH: w_state_next = ST_DECODE;
            ST_DECODE: begin
                w_is_sw_next = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: w_state_next = ST_MEM_ADDR;
                    OP_RTYPE:     w_state_next = ST_R_EXEC;
                    OP_BEQ:       w_state_next = ST_BRANCH;
                    OP_J:         w_state_next = ST_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      w_state_next = ST_ADDI_EXEC;
`endif
                    default:      w_state_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  w_state_next = r_is_sw ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    w_state_next = ST_MEM_WB;
            ST_R_EXEC:    w_state_next = ST_R_WB;
`ifdef MIPS_CTRL_ADDI_EN
            ST_ADDI_EXEC: w_state_next = ST_ADDI_WB;
`endif
            // Final states and any unused encoding return to FETCH.
            default:      w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_is_sw <= w_is_sw_next;
        end
    end

    mips_ctrl_outdec #(
        .STATE_W (STATE_W)
    ) u_outdec (
        .state (r_state),
        .ctrl  (w_ctrl)
    );

    assign w_illegal = (r_state == ST_DECODE) && !op_is_legal(opcode);

    // FETCH is encoding 0 and decodes to a non-zero word, so the outputs are
    // gated combinationally by rst_n to read all-zero during reset.
    assign w_ctrl_gated  = rst_n ? w_ctrl : CTRL_IDLE;

    assign pc_write      = w_ctrl_gated.pc_write;
    assign pc_write_cond = w_ctrl_gated.pc_write_cond;
    assign i_or_d        = w_ctrl_gated.i_or_d;
    assign mem_read      = w_ctrl_gated.mem_read;
    assign mem_write     = w_ctrl_gated.mem_write;
    assign ir_write      = w_ctrl_gated.ir_write;
    assign mem_to_reg    = w_ctrl_gated.mem_to_reg;
    assign reg_dst       = w_ctrl_gated.reg_dst;
    assign reg_write     = w_ctrl_gated.reg_write;
    assign alu_src_a     = w_ctrl_gated.alu_src_a;
    assign alu_src_b     = w_ctrl_gated.alu_src_b;
    assign alu_op        = w_ctrl_gated.alu_op;
    assign pc_source     = w_ctrl_gated.pc_source;
    assign instr_done    = w_ctrl_gated.instr_done;
    assign illegal_op    = rst_n & w_illegal;
    assign state         = rst_n ? r_state : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Randomized instruction stream against a sequence-level reference model.
// The driver pushes the expected per-cycle output words and the expected
// instruction latency into queues; an independent monitor on the falling
// edge pops and compares. Honors MIPS_CTRL_ADDI_EN for the addi opcode.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    mips_multicycle_ctrl #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       done, ill;
    } obs_t;

    obs_t       exp_q[$];
    int         lat_q[$];
    logic [5:0] op_q[$];
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    int         cyc_cnt = 0;
    int         n_instr = 0;

`ifdef MIPS_CTRL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    function automatic obs_t sample_dut();
        obs_t o;
        o = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source, instr_done, illegal_op};
        return o;
    endfunction

    // Output word for one step of an instruction, straight from the state table.
    function automatic obs_t step_word(int st, bit ill);
        obs_t w;
        w = '0;
        w.st = st[3:0];
        case (st)
            0:  begin w.mr = 1; w.irw = 1; w.srcb = 2'b01; w.pcw = 1; end
            1:  begin w.srcb = 2'b11; w.ill = ill; end
            2:  begin w.srca = 1; w.srcb = 2'b10; end
            3:  begin w.mr = 1; w.iord = 1; end
            4:  begin w.rw = 1; w.m2r = 1; w.done = 1; end
            5:  begin w.mw = 1; w.iord = 1; w.done = 1; end
            6:  begin w.srca = 1; w.aluop = 2'b10; end
            7:  begin w.rw = 1; w.rdst = 1; w.done = 1; end
            8:  begin w.srca = 1; w.aluop = 2'b01; w.pcwc = 1; w.pcsrc = 2'b01; w.done = 1; end
            9:  begin w.pcw = 1; w.pcsrc = 2'b10; w.done = 1; end
            10: begin w.srca = 1; w.srcb = 2'b10; end
            11: begin w.rw = 1; w.done = 1; end
            default: w = '0;
        endcase
        return w;
    endfunction

    // Push the expected visit sequence for one instruction; returns latency.
    function automatic int push_instr(logic [5:0] op);
        int seq[$];
        bit ill;
        ill = 1'b0;
        if (op == 6'h23)                 seq = {0, 1, 2, 3, 4};
        else if (op == 6'h2B)            seq = {0, 1, 2, 5};
        else if (op == 6'h00)            seq = {0, 1, 6, 7};
        else if (op == 6'h04)            seq = {0, 1, 8};
        else if (op == 6'h02)            seq = {0, 1, 9};
        else if (op == 6'h08 && ADDI_ON) seq = {0, 1, 10, 11};
        else begin seq = {0, 1}; ill = 1'b1; end
        foreach (seq[i]) exp_q.push_back(step_word(seq[i], ill && (i == 1)));
        lat_q.push_back(seq.size());
        op_q.push_back(op);
        return seq.size();
    endfunction

    task automatic run_instr(input logic [5:0] op);
        int n;
        opcode = op;
        n = push_instr(op);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: per-cycle word compare, exclusivity, and per-instruction latency.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            obs_t a, e;
            a = sample_dut();
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cyc_underflow: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL cyc_word: got %h expected %h", a, e);
                end
            end
            total++;
            if ((mem_read && mem_write) || (pc_write && pc_write_cond)) begin
                bad++;
                $display("FAIL exclusive: mr=%0b mw=%0b pcw=%0b pcwc=%0b required no overlap",
                         mem_read, mem_write, pc_write, pc_write_cond);
            end
            cyc_cnt = (state == 4'd0) ? 1 : cyc_cnt + 1;
            if (instr_done || illegal_op) begin
                int       l;
                logic [5:0] o;
                total++;
                if (lat_q.size() == 0) begin
                    bad++;
                    $display("FAIL lat_underflow: got end of instr expected none");
                end else begin
                    l = lat_q.pop_front();
                    o = op_q.pop_front();
                    n_instr++;
                    if (cyc_cnt != l) begin
                        bad++;
                        $display("FAIL latency: op=%h got %0d required %0d", o, cyc_cnt, l);
                    end else
                        $display("instr %0d op=%h latency=%0d ill=%0b", n_instr, o, l, illegal_op);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    logic [5:0] dir_ops[7];
    logic [5:0] pool[6];

    initial begin
        logic [5:0] op;
        dir_ops = '{6'h23, 6'h00, 6'h04, 6'h02, 6'h2B, 6'h3F, 6'h08};
        pool    = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};

        #2;
        check_now("reset_state", sample_dut(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        foreach (dir_ops[i]) run_instr(dir_ops[i]);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
            else op = pool[$urandom_range(0, 5)];
            run_instr(op);
        end

        // Reset in the middle of a lw, while in MEM_RD.
        mon_en = 1'b0;
        opcode = 6'h23;
        repeat (3) @(posedge clk);
        #1;
        check_now("pre_reset_memrd", sample_dut(), step_word(3, 1'b0));
        rst_n = 1'b0;
        #1;
        check_now("async_reset", sample_dut(), '0);
        @(posedge clk); #1;
        check_now("held_reset", sample_dut(), '0);
        rst_n = 1'b1;
        #1;
        check_now("post_reset_fetch", sample_dut(), step_word(0, 1'b0));
        mon_en = 1'b1;

        for (int k = 0; k < 20; k++) run_instr(pool[$urandom_range(0, 5)]);

        total++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d left required 0/0", exp_q.size(), lat_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
